// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, stall/redirect handling.
// Optional misaligned-redirect trap is compiled in with `define FETCH_MISALIGN_TRAP_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [31:0] inst_i,
  output logic [31:0] pc_o,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_inst_o,
  output logic [31:0] ifid_pc_plus_4_o,
  output logic        misalign_o,
  output logic [31:0] misalign_addr_o
);

  logic [31:0] pc_reg;
  logic [31:0] pc_plus_4;
  logic [31:0] redirect_target;
  logic        ifid_valid_reg;
  logic [31:0] ifid_pc_reg;
  logic [31:0] ifid_inst_reg;
  logic [31:0] ifid_pc_plus_4_reg;

  assign pc_plus_4 = pc_reg + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misaligned;
  logic        misalign_reg;
  logic [31:0] misalign_addr_reg;

  assign misaligned = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  // Trap vector is force-aligned so the fetch address never has low bits set.
  assign redirect_target = (redirect_pc_i[1:0] != 2'b00) ? {TRAP_PC[31:2], 2'b00}
                                                         : redirect_pc_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      misalign_reg      <= 1'b0;
      misalign_addr_reg <= 32'h0;
    end else begin
      misalign_reg <= misaligned;
      if (misaligned) begin
        misalign_addr_reg <= redirect_pc_i;
      end
    end
  end

  assign misalign_o      = misalign_reg;
  assign misalign_addr_o = misalign_addr_reg;
`else
  logic unused_trap_bits;

  assign redirect_target  = {redirect_pc_i[31:2], 2'b00};
  assign unused_trap_bits = ^{redirect_pc_i[1:0], TRAP_PC};
  assign misalign_o       = 1'b0;
  assign misalign_addr_o  = 32'h0;
`endif

  // Priority: reset > redirect > stall > advance.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_reg             <= RESET_PC;
      ifid_valid_reg     <= 1'b0;
      ifid_pc_reg        <= 32'h0;
      ifid_inst_reg      <= NOP_INST;
      ifid_pc_plus_4_reg <= 32'h0;
    end else if (redirect_i) begin
      pc_reg             <= redirect_target;
      ifid_valid_reg     <= 1'b0;
      ifid_pc_reg        <= 32'h0;
      ifid_inst_reg      <= NOP_INST;
      ifid_pc_plus_4_reg <= 32'h0;
    end else if (!stall_i) begin
      pc_reg             <= pc_plus_4;
      ifid_valid_reg     <= 1'b1;
      ifid_pc_reg        <= pc_reg;
      ifid_inst_reg      <= inst_i;
      ifid_pc_plus_4_reg <= pc_plus_4;
    end
  end

  assign pc_o             = pc_reg;
  assign ifid_valid_o     = ifid_valid_reg;
  assign ifid_pc_o        = ifid_pc_reg;
  assign ifid_inst_o      = ifid_inst_reg;
  assign ifid_pc_plus_4_o = ifid_pc_plus_4_reg;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: reset, free-run, stall, redirect, wrap, misaligned redirect.
// Misalign expectations follow `define FETCH_MISALIGN_TRAP_EN, as in the RTL.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc_plus_4;
  logic        misalign;
  logic [31:0] misalign_addr;

  int n_checks = 0;
  int n_errors = 0;

  if_stage dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .stall_i         (stall),
    .redirect_i      (redirect),
    .redirect_pc_i   (redirect_pc),
    .inst_i          (inst),
    .pc_o            (pc),
    .ifid_valid_o    (ifid_valid),
    .ifid_pc_o       (ifid_pc),
    .ifid_inst_o     (ifid_inst),
    .ifid_pc_plus_4_o(ifid_pc_plus_4),
    .misalign_o      (misalign),
    .misalign_addr_o (misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational IROM model.
  assign inst = pc ^ 32'hA5A5_0000;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [31:0] p,
                            input logic [31:0] i, input logic [31:0] p4);
    check_eq({tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, v});
    check_eq({tag, ".pc"}, ifid_pc, p);
    check_eq({tag, ".inst"}, ifid_inst, i);
    check_eq({tag, ".pc4"}, ifid_pc_plus_4, p4);
    $display("txn %-10s pc=%08h ifid v=%0d pc=%08h inst=%08h pc4=%08h mis=%0d addr=%08h",
             tag, pc, ifid_valid, ifid_pc, ifid_inst, ifid_pc_plus_4, misalign, misalign_addr);
  endtask

  logic [31:0] exp_addr;
  logic        exp_mis;

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    check_eq("rst.pc", pc, 32'h0);
    check_eq("rst.mis", {31'h0, misalign}, 32'h0);
    check_eq("rst.addr", misalign_addr, 32'h0);
    check_ifid("rst", 1'b0, 32'h0, 32'h13, 32'h0);

    // Free-run
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("run.pc", pc, 32'(4 * (k + 1)));
      check_ifid("run", 1'b1, 32'(4 * k), 32'(4 * k) ^ 32'hA5A5_0000, 32'(4 * k + 4));
    end

    // Stall three cycles at pc 0x10
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("stall.pc", pc, 32'h10);
      check_ifid("stall", 1'b1, 32'h0C, 32'hA5A5_000C, 32'h10);
    end
    stall = 1'b0;
    tick();
    check_eq("rel.pc", pc, 32'h14);
    check_ifid("rel0", 1'b1, 32'h10, 32'hA5A5_0010, 32'h14);
    tick();
    check_ifid("rel1", 1'b1, 32'h14, 32'hA5A5_0014, 32'h18);
    tick(); tick();
    check_eq("pre_redir.pc", pc, 32'h20);

    // Redirect with simultaneous stall
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect = 1'b0; stall = 1'b0;
    check_eq("redir.pc", pc, 32'h80);
    check_ifid("redir", 1'b0, 32'h0, 32'h13, 32'h0);
    tick();
    check_eq("redir1.pc", pc, 32'h84);
    check_ifid("redir1", 1'b1, 32'h80, 32'hA5A5_0080, 32'h84);

    // Wrap around the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check_eq("wrap.pc", pc, 32'hFFFF_FFFC);
    tick();
    check_eq("wrap1.pc", pc, 32'h0);
    check_ifid("wrap1", 1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 32'h0);

    // Misaligned redirect
`ifdef FETCH_MISALIGN_TRAP_EN
    exp_addr = 32'h102; exp_mis = 1'b1;
`else
    exp_addr = 32'h0;   exp_mis = 1'b0;
`endif
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    check_eq("mis.pc", pc, 32'h100);
    check_eq("mis.pulse", {31'h0, misalign}, {31'h0, exp_mis});
    check_eq("mis.addr", misalign_addr, exp_addr);
    check_ifid("mis", 1'b0, 32'h0, 32'h13, 32'h0);
    tick();
    check_eq("mis1.pc", pc, 32'h104);
    check_eq("mis1.pulse", {31'h0, misalign}, 32'h0);
    check_eq("mis1.addr", misalign_addr, exp_addr);
    check_ifid("mis1", 1'b1, 32'h100, 32'hA5A5_0100, 32'h104);

    // Aligned redirect leaves the trap address alone
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    check_eq("al.pc", pc, 32'h40);
    check_eq("al.pulse", {31'h0, misalign}, 32'h0);
    check_eq("al.addr", misalign_addr, exp_addr);

    // Misaligned redirect held off by a simultaneous reset
    tick();
    reset = 1'b1; redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h203;
    tick();
    reset = 1'b0; redirect = 1'b0; stall = 1'b0;
    check_eq("rstred.pc", pc, 32'h0);
    check_eq("rstred.mis", {31'h0, misalign}, 32'h0);
    check_eq("rstred.addr", misalign_addr, 32'h0);
    check_ifid("rstred", 1'b0, 32'h0, 32'h13, 32'h0);
    tick();
    check_eq("post.pc", pc, 32'h4);
    check_ifid("post", 1'b1, 32'h0, 32'hA5A5_0000, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
